// File: rtl/instr_encoder_loader.sv
// Packs decoded fields into 16-bit words, buffers them in a DEPTH-entry FIFO, streams them to imem (INSTR_ENC_CHECKSUM_EN adds checksum).
// Latency: accept -> imem_we one edge later; in_ready drops when FIFO full, load_en=0 stalls the drain.
module instr_encoder_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              load_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_ra,
    input  logic [3:0]        in_rb,
    input  logic [3:0]        in_rc,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [15:0]       words_written,
`ifdef INSTR_ENC_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              err_range,
    output logic              wrapped
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_LDR  = 4'd10;
    localparam logic [3:0] OP_STR  = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_B    = 4'd13;
    localparam logic [3:0] OP_BL   = 4'd14;
    localparam logic [3:0] OP_BR   = 4'd15;

    logic [15:0]       mem_q [DEPTH];
    logic [15:0]       mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d, imem_addr_q, imem_addr_d;
    logic [15:0]       imem_wdata_q, imem_wdata_d, words_q, words_d, csum_q, csum_d;
    logic              imem_we_q, imem_we_d, err_q, err_d, wrapped_q, wrapped_d;
    logic [15:0]       packed_word;
    logic              imm_short, imm_bad, push, pop, full;

    // Field packing; R-type opcodes fall through to the default format.
    always_comb begin
        packed_word = {in_opcode, in_ra, in_rb, in_rc};
        imm_short   = 1'b0;
        case (in_opcode)
            OP_ADDI, OP_LSL, OP_LSR, OP_LDR, OP_STR, OP_BEQ: begin
                packed_word = {in_opcode, in_ra, in_rb, in_imm[3:0]};
                imm_short   = 1'b1;
            end
            OP_B, OP_BL: packed_word = {in_opcode, in_imm};
            OP_BR:       packed_word = {in_opcode, in_ra, 8'h00};
            default:     ;
        endcase
        imm_bad = imm_short && (in_imm[11:4] != {8{in_imm[3]}});
    end

    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready && !load_start;
    assign pop      = load_en && (count_q != '0) && !load_start;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        addr_d       = addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        words_d      = words_q;
        err_d        = err_q;
        wrapped_d    = wrapped_q;
        csum_d       = csum_q;
        if (load_start) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            addr_d    = base_addr;
            words_d   = '0;
            err_d     = 1'b0;
            wrapped_d = 1'b0;
            csum_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = packed_word;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                if (imm_bad) err_d = 1'b1;
            end
            if (pop) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = addr_q;
                imem_wdata_d = mem_q[rd_ptr_q];
                csum_d       = csum_q ^ mem_q[rd_ptr_q];
                rd_ptr_d     = rd_ptr_q + PW'(1);
                addr_d       = addr_q + ADDR_W'(1);
                if (&addr_q) wrapped_d = 1'b1;
                if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            words_q      <= '0;
            err_q        <= 1'b0;
            wrapped_q    <= 1'b0;
            csum_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            words_q      <= words_d;
            err_q        <= err_d;
            wrapped_q    <= wrapped_d;
            csum_q       <= csum_d;
        end
    end

    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign words_written = words_q;
    assign err_range     = err_q;
    assign wrapped       = wrapped_q;
`ifdef INSTR_ENC_CHECKSUM_EN
    assign checksum      = csum_q;
`else
    logic unused_csum;
    assign unused_csum   = ^csum_q;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader with a queue-based reference model and directed literal checks.
module tb_instr_encoder_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              load_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_opcode = '0, in_ra = '0, in_rb = '0, in_rc = '0;
    logic [11:0]       in_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata, words_written;
    logic              err_range, wrapped;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .load_en(load_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .words_written(words_written),
`ifdef INSTR_ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err_range(err_range), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode classes: 0-6 register, 7-12 short immediate, 13-14 long immediate, 15 register branch.
    function automatic logic [15:0] ref_pack(input logic [3:0] op, input logic [3:0] ra,
                                             input logic [3:0] rb, input logic [3:0] rc,
                                             input logic [11:0] imm);
        int o = int'(op);
        if (o <= 6)       return {op, ra, rb, rc};
        else if (o <= 12) return {op, ra, rb, imm[3:0]};
        else if (o <= 14) return {op, imm};
        else              return {op, ra, 8'h00};
    endfunction

    function automatic bit ref_bad(input logic [3:0] op, input logic [11:0] imm);
        int v = int'($signed(imm));
        return (int'(op) >= 7 && int'(op) <= 12) && (v < -8 || v > 7);
    endfunction

    logic [15:0] q[$];
    logic        m_we = 0, m_err = 0, m_wrap = 0;
    logic [ADDR_W-1:0] m_addr = 0, m_ctr = 0;
    logic [15:0] m_wdata = 0, m_ww = 0, m_cs = 0;

    always @(posedge clk) begin
        bit do_push, do_pop;
        logic [15:0] w;
        if (rst) begin
            q.delete();
            m_we = 0; m_addr = 0; m_wdata = 0; m_ww = 0; m_err = 0; m_wrap = 0; m_cs = 0; m_ctr = 0;
        end else if (load_start) begin
            q.delete();
            m_we = 0; m_ctr = base_addr; m_ww = 0; m_err = 0; m_wrap = 0; m_cs = 0;
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = load_en && (q.size() > 0);
            m_we = 0;
            if (do_pop) begin
                w = q.pop_front();
                m_we = 1; m_addr = m_ctr; m_wdata = w; m_cs = m_cs ^ w;
                if (m_ww != 16'hFFFF) m_ww = m_ww + 1;
                if (int'(m_ctr) == (1 << ADDR_W) - 1) m_wrap = 1;
                m_ctr = m_ctr + 1;
            end
            if (do_push) begin
                q.push_back(ref_pack(in_opcode, in_ra, in_rb, in_rc, in_imm));
                if (ref_bad(in_opcode, in_imm)) m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, !rst && (q.size() < DEPTH));
            check("imem_we", imem_we, m_we);
            if (m_we) begin
                check("imem_addr", imem_addr, m_addr);
                check("imem_wdata", imem_wdata, m_wdata);
            end
            check("words_written", words_written, m_ww);
            check("err_range", err_range, m_err);
            check("wrapped", wrapped, m_wrap);
`ifdef INSTR_ENC_CHECKSUM_EN
            check("checksum", checksum, m_cs);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [11:0] imm);
        in_valid = 1; in_opcode = op; in_ra = ra; in_rb = rb; in_rc = rc; in_imm = imm;
    endtask

    task automatic restart(input logic [ADDR_W-1:0] base);
        load_start = 1; base_addr = base;
        cyc();
        load_start = 0;
    endtask

    initial begin
        int acc, nw;
        logic [ADDR_W-1:0] seen[3];
        logic [3:0] r4;

        // Reset state
        rst = 1;
        cyc();
        chk_en = 1;
        check("rst_ready", in_ready, 1'b0);
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_wdata", imem_wdata, 16'h0000);
        check("rst_ww", words_written, 16'h0000);
        check("rst_err", err_range, 1'b0);
        check("rst_wrap", wrapped, 1'b0);
        cyc();
        rst = 0;
        #1;
        check("post_rst_ready", in_ready, 1'b1);

        // First word at base 0x10, two edges after being presented
        load_en = 1;
        restart(8'h10);
        drive(4'd0, 4'd1, 4'd2, 4'd3, 12'h000);
        cyc();
        in_valid = 0;
        check("lat_we_early", imem_we, 1'b0);
        cyc();
        check("first_we", imem_we, 1'b1);
        check("first_addr", imem_addr, 8'h10);
        check("first_wdata", imem_wdata, 16'h0123);
        check("first_ww", words_written, 16'd1);
        cyc();
        check("first_we_one_cycle", imem_we, 1'b0);

        // Immediate range: -7 fits, +9 does not
        drive(4'd7, 4'd1, 4'd2, 4'd0, 12'hFF9);
        cyc();
        check("imm_neg_ok", err_range, 1'b0);
        drive(4'd7, 4'd1, 4'd2, 4'd0, 12'h009);
        cyc();
        in_valid = 0;
        check("imm_pos_err", err_range, 1'b1);
        check("imm_neg_word", imem_wdata, 16'h7129);
        cyc();
        check("imm_bad_written", imem_we, 1'b1);
        check("imm_bad_word", imem_wdata, 16'h7129);
        cyc();

        // Fill with load_en low, then drain four words back-to-back
        restart(8'h40);
        load_en = 0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (!in_ready) break;
            drive(4'd1, 4'(i), 4'd5, 4'd6, 12'h000);
            cyc();
            acc++;
        end
        in_valid = 0;
        check("fill_count", acc, DEPTH);
        check("fill_ready_low", in_ready, 1'b0);
        load_en = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("drain_we", imem_we, 1'b1);
            check("drain_addr", imem_addr, 8'h40 + 8'(k));
            check("drain_order", imem_wdata[11:8], 4'(k));
            if (k == 0) check("ready_after_pop", in_ready, 1'b1);
        end
        cyc();
        check("drain_done", imem_we, 1'b0);

        // Address wrap
        restart(8'hFE);
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(4'd13, 4'd0, 4'd0, 4'd0, 12'(i)); else in_valid = 0;
            cyc();
            if (imem_we && nw < 3) begin seen[nw] = imem_addr; nw++; end
        end
        check("wrap_count", nw, 3);
        check("wrap_a0", seen[0], 8'hFE);
        check("wrap_a1", seen[1], 8'hFF);
        check("wrap_a2", seen[2], 8'h00);
        check("wrap_flag", wrapped, 1'b1);

        // load_start discards buffered words and the coincident bundle
        restart(8'h20);
        load_en = 0;
        drive(4'd2, 4'd1, 4'd1, 4'd1, 12'h000); cyc();
        drive(4'd3, 4'd2, 4'd2, 4'd2, 12'h000); cyc();
        drive(4'd4, 4'd3, 4'd3, 4'd3, 12'h000);
        load_start = 1;
        cyc();
        load_start = 0; in_valid = 0; load_en = 1;
        nw = 0;
        for (int i = 0; i < 5; i++) begin cyc(); if (imem_we) nw++; end
        check("flush_no_writes", nw, 0);
        check("flush_ww", words_written, 16'd0);
        check("flush_wrap", wrapped, 1'b0);

`ifdef INSTR_ENC_CHECKSUM_EN
        restart(8'h00);
        drive(4'd0, 4'd1, 4'd2, 4'd3, 12'h000); cyc();
        drive(4'd12, 4'd0, 4'd0, 4'd0, 12'h005); cyc();
        in_valid = 0;
        cyc(); cyc();
        check("csum_value", checksum, 16'hC126);
        restart(8'h00);
        check("csum_clear", checksum, 16'h0000);
`endif

        // Randomized traffic, with occasional load_start and mid-stream reset
        for (int i = 0; i < 4000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 4) != 0);
            load_start = ($urandom_range(0, 63) == 0);
            base_addr  = ($urandom_range(0, 2) == 0) ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
            rst        = ($urandom_range(0, 499) == 0);
            in_opcode  = 4'($urandom);
            in_ra      = 4'($urandom);
            in_rb      = 4'($urandom);
            in_rc      = 4'($urandom);
            r4         = 4'($urandom);
            in_imm     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {{8{r4[3]}}, r4};
            cyc();
        end
        rst = 0; load_start = 0; in_valid = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 16-bit instruction words.
- Buffers packed words in a small FIFO and streams them into instruction memory at an auto-incrementing address.
- Used as the program loader feeding the instruction memory ahead of the fetch/decode path.

Parameters:
- DEPTH, 4, FIFO depth in words. Power of two, at least 2.
- ADDR_W, 8, instruction-memory address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse: flush FIFO and output stage, set address to base_addr, clear err_range and counters
- base_addr  in  ADDR_W  start address, sampled on load_start
- load_en  in  1  when low, draining into memory stalls; FIFO keeps accepting
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_opcode  in  4  opcode, values per macro_defines.v
- in_ra  in  4  first register field
- in_rb  in  4  second register field
- in_rc  in  4  third register field
- in_imm  in  12  immediate, two's complement
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  packed instruction
- words_written  out  16  count of imem writes since reset/load_start
- err_range  out  1  sticky: an immediate did not fit its field
- wrapped  out  1  sticky: address wrapped from all-ones to zero

Behaviour:
- Reset (rst high at an edge): FIFO empty, in_ready=0 during the reset cycle and 1 afterwards, imem_we=0, imem_addr=0, imem_wdata=0, words_written=0, err_range=0, wrapped=0. Reset mid-stream drops all buffered words.
- Packing; opcode is always in [15:12]:
  - R-type (add, sub, and, or, xor, not, slt): {op, ra, rb, rc}.
  - I-type (addi, lsl, lsr, ldr, str): {op, ra, rb, imm[3:0]}.
  - beq: {op, ra, rb, imm[3:0]}.
  - b, bl: {op, imm[11:0]}.
  - br: {op, ra, 8'h00}.
- Range check applies only to 4-bit-imm formats. If imm[11:4] is not all copies of imm[3], set err_range. The word is still packed with the truncated imm[3:0] and written.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !fifo_full. There is no bypass, so a pop in the same cycle does not raise in_ready.
  - Inputs need be stable only in the transfer cycle.
- Drain stage is a registered output.
  - At each edge where load_en=1 and the FIFO is non-empty, pop the head into imem_wdata. imem_addr takes the current address counter, imem_we=1, and the counter increments.
  - Otherwise imem_we=0; imem_addr and imem_wdata hold their values.
- Latency: a bundle accepted at edge E0 is written to the FIFO at E0, appears on imem_* after E1, and imem_we is high for exactly one cycle. Sustained throughput is 1 word/cycle.
- FIFO full with simultaneous pop and push attempt: the pop proceeds and the push is refused (in_ready was 0).
- Address wrap: the increment from 2^ADDR_W-1 goes to 0 and sets wrapped. Writing continues.
- words_written increments with each imem_we and saturates at 16'hFFFF.
- load_start:
  - Takes priority over push and pop in the same cycle. A coincident transfer is discarded.
  - Next cycle: FIFO empty, imem_we=0, address=base_addr, words_written=0, err_range=0, wrapped=0.
- load_start and rst together: rst wins (address=0).

Optional Feature:
- Macro INSTR_ENC_CHECKSUM_EN.
- Defined:
  - Adds output checksum[15:0], the running XOR of every imem_wdata written.
  - Updated in the same edge as imem_we.
  - Cleared to 0 by rst or load_start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, load_start with base_addr=8'h10, then push add with ra=1, rb=2, rc=3 → two cycles later imem_we=1 for one cycle, imem_addr=8'h10, imem_wdata=16'h0123 (add=0), words_written=1.
- Push addi with imm=12'hFF9 (−7), then imm=12'h009 → first word has low nibble 4'h9, err_range stays 0; the 12'h009 push sets err_range=1 while its word is still written.
- Hold load_en=0 and push until in_ready=0 (exactly DEPTH=4 accepted) → raise load_en → four consecutive imem_we cycles at ascending addresses, in order; in_ready=1 after the first pop.
- base_addr=8'hFE, push 3 words → addresses FE, FF, 00; wrapped=1 after the third write.
- Assert load_start while 2 words are buffered and in_valid=1 → no further imem_we, words_written=0, the buffered words and the coincident bundle are discarded.
- With INSTR_ENC_CHECKSUM_EN: write 16'h0123 then 16'hC005 → checksum=16'hC126; after load_start checksum=0.
